// File: rtl/post_spike_aer_encoder.sv
// Post-neuron spike vector to AER serialiser.
// A spike vector is latched into a staging register, its set lanes are
// converted one per cycle (lowest lane first) into neuron addresses, pushed
// into an address FIFO, and drained over a 4-phase REQ/ACK AER link.
module post_spike_aer_encoder #(
   parameter int POST_NEUR_PARALLEL   = 4,
   parameter int POST_NEUR_ADDR_WIDTH = 10,
   parameter int AER_WIDTH            = 12,
   parameter int AER_EVENT_TAG        = 0,
   parameter int FIFO_DEPTH           = 16
) (
   input  logic                               CLK,
   input  logic                               RST_N,
   input  logic                               SPIKE_VALID,
   input  logic [POST_NEUR_PARALLEL-1:0]      SPIKE_VEC,
   input  logic [POST_NEUR_ADDR_WIDTH-1:0]    SPIKE_BASE_ADDR,
   output logic                               SPIKE_READY,
   output logic [AER_WIDTH-1:0]               AER_OUT_ADDR,
   output logic                               AER_OUT_REQ,
   input  logic                               AER_OUT_ACK,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    FIFO_COUNT,
   output logic                               OVERFLOW,
   input  logic                               CLR_OVERFLOW
);

   localparam int LANE_W = (POST_NEUR_PARALLEL > 1) ? $clog2(POST_NEUR_PARALLEL) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

   // Tag bits sit above the neuron address; they vanish when the widths match.
   localparam logic [AER_WIDTH-1:0] TAG_WORD = AER_WIDTH'(AER_EVENT_TAG) << POST_NEUR_ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10
   } aer_state_t;

   // Staging register (one vector being serialised)
   logic [POST_NEUR_PARALLEL-1:0]   stg_vec_p0;
   logic [POST_NEUR_ADDR_WIDTH-1:0] stg_base_p0;

   // Lane selection
   logic                            lane_hit;
   logic [LANE_W-1:0]               lane_idx;
   logic [POST_NEUR_PARALLEL-1:0]   lane_mask;
   logic [POST_NEUR_ADDR_WIDTH-1:0] push_addr;

   // FIFO
   logic [POST_NEUR_ADDR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]                wr_ptr;
   logic [PTR_W-1:0]                rd_ptr;
   logic [CNT_W-1:0]                fifo_cnt;
   logic                            fifo_empty;
   logic                            fifo_full;
   logic [POST_NEUR_ADDR_WIDTH-1:0] fifo_head;

   // Handshake control
   logic       capture;
   logic       drop;
   logic       push;
   logic       pop;
   logic       load_addr;
   logic       ack_meta_p0;
   logic       ack_s_p1;
   aer_state_t state;
   aer_state_t state_nxt;

   assign SPIKE_READY = ~|stg_vec_p0;
   assign capture     = SPIKE_VALID && SPIKE_READY && (|SPIKE_VEC);
   assign drop        = SPIKE_VALID && !SPIKE_READY && (|SPIKE_VEC);

   assign fifo_empty  = (fifo_cnt == '0);
   assign fifo_full   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign fifo_head   = fifo_mem[rd_ptr];
   assign FIFO_COUNT  = fifo_cnt;

   // A full FIFO still accepts a push in the cycle it is being popped.
   assign push        = lane_hit && (!fifo_full || pop);
   assign push_addr   = stg_base_p0 + POST_NEUR_ADDR_WIDTH'(lane_idx);

   // Priority encoder: lowest set staging lane and its one-hot clear mask.
   always_comb begin
      lane_hit  = 1'b0;
      lane_idx  = '0;
      lane_mask = '0;
      for (int i = POST_NEUR_PARALLEL - 1; i >= 0; i--) begin
         if (stg_vec_p0[i]) begin
            lane_hit     = 1'b1;
            lane_idx     = LANE_W'(i);
            lane_mask    = '0;
            lane_mask[i] = 1'b1;
         end
      end
   end

   // Staging register: load an accepted vector, then retire one lane per push.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stg_vec_p0  <= '0;
         stg_base_p0 <= '0;
      end else if (capture) begin
         stg_vec_p0  <= SPIKE_VEC;
         stg_base_p0 <= SPIKE_BASE_ADDR;
      end else if (push) begin
         stg_vec_p0  <= stg_vec_p0 & ~lane_mask;
      end
   end

   // Sticky overflow flag; a drop in the same cycle beats a clear.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OVERFLOW <= 1'b0;
      end else if (drop) begin
         OVERFLOW <= 1'b1;
      end else if (CLR_OVERFLOW) begin
         OVERFLOW <= 1'b0;
      end
   end

   // FIFO storage holds pure data and needs no reset.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr] <= push_addr;
      end
   end

   // FIFO pointers and exact occupancy; pointers wrap naturally (power-of-2 depth).
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Two-flop synchroniser for the asynchronous acknowledge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ack_meta_p0 <= 1'b0;
         ack_s_p1    <= 1'b0;
      end else begin
         ack_meta_p0 <= AER_OUT_ACK;
         ack_s_p1    <= ack_meta_p0;
      end
   end

   // Output FSM state register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Output FSM next state: 4-phase REQ/ACK sequencing.
   always_comb begin
      state_nxt = state;
      load_addr = 1'b0;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty && !ack_s_p1) begin
               load_addr = 1'b1;
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (ack_s_p1) begin
               pop       = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!ack_s_p1) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Link outputs are dedicated flops so REQ never glitches on state decode;
   // the address is only loaded on entry to REQ and therefore stable while REQ=1.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         AER_OUT_REQ  <= 1'b0;
         AER_OUT_ADDR <= '0;
      end else begin
         AER_OUT_REQ <= (state_nxt == S_REQ);
         if (load_addr) begin
            AER_OUT_ADDR <= TAG_WORD | AER_WIDTH'(fifo_head);
         end
      end
   end

endmodule

// File: tb/tb_post_spike_aer_encoder.sv
// Bench for post_spike_aer_encoder: directed scenarios plus random traffic,
// scoreboarded by an AER receiver process.
module tb_post_spike_aer_encoder;

   localparam int P     = 4;
   localparam int AW    = 10;
   localparam int W     = 12;
   localparam int TAG   = 0;
   localparam int DEPTH = 16;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          SPIKE_VALID;
   logic [P-1:0]  SPIKE_VEC;
   logic [AW-1:0] SPIKE_BASE_ADDR;
   logic          SPIKE_READY;
   logic [W-1:0]  AER_OUT_ADDR;
   logic          AER_OUT_REQ;
   logic          AER_OUT_ACK;
   logic [4:0]    FIFO_COUNT;
   logic          OVERFLOW;
   logic          CLR_OVERFLOW;

   post_spike_aer_encoder #(
      .POST_NEUR_PARALLEL  (P),
      .POST_NEUR_ADDR_WIDTH(AW),
      .AER_WIDTH           (W),
      .AER_EVENT_TAG       (TAG),
      .FIFO_DEPTH          (DEPTH)
   ) dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .SPIKE_VALID    (SPIKE_VALID),
      .SPIKE_VEC      (SPIKE_VEC),
      .SPIKE_BASE_ADDR(SPIKE_BASE_ADDR),
      .SPIKE_READY    (SPIKE_READY),
      .AER_OUT_ADDR   (AER_OUT_ADDR),
      .AER_OUT_REQ    (AER_OUT_REQ),
      .AER_OUT_ACK    (AER_OUT_ACK),
      .FIFO_COUNT     (FIFO_COUNT),
      .OVERFLOW       (OVERFLOW),
      .CLR_OVERFLOW   (CLR_OVERFLOW)
   );

   always #5 CLK = ~CLK;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_rx    = 0;
   logic [W-1:0] exp_q[$];
   bit         rx_hold = 1'b0;
   bit         model_ovf = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: AER word = tag above the wrapped neuron address base+lane.
   function automatic logic [W-1:0] aer_word(input int base, input int lane);
      return W'((TAG * 1024) + ((base + lane) % 1024));
   endfunction

   // Drive one cycle of input, predict the response, check the overflow flag.
   task automatic send_vec(input bit v, input logic [P-1:0] vec, input int base, input bit clr);
      bit dropped;
      @(negedge CLK);
      SPIKE_VALID     = v;
      SPIKE_VEC       = vec;
      SPIKE_BASE_ADDR = AW'(base);
      CLR_OVERFLOW    = clr;
      dropped = 1'b0;
      if (v && vec != '0) begin
         if (SPIKE_READY) begin
            for (int i = 0; i < P; i++)
               if (vec[i]) exp_q.push_back(aer_word(base, i));
         end else begin
            dropped = 1'b1;
         end
      end
      if (dropped) model_ovf = 1'b1;
      else if (clr) model_ovf = 1'b0;
      @(negedge CLK);
      SPIKE_VALID  = 1'b0;
      SPIKE_VEC    = '0;
      CLR_OVERFLOW = 1'b0;
      check("overflow", 32'(OVERFLOW), 32'(model_ovf));
   endtask

   task automatic wait_ready();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge CLK);
         if (SPIKE_READY) begin
            ok = 1'b1;
            break;
         end
      end
      check("ready_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge CLK);
         if (exp_q.size() == 0 && !AER_OUT_REQ && !AER_OUT_ACK) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (6) @(negedge CLK);
      check("drain_done", 32'(ok), 32'd1);
      check("drain_left", 32'(exp_q.size()), 32'd0);
      check("drain_count", 32'(FIFO_COUNT), 32'd0);
   endtask

   // AER receiver: checks each offered word against the scoreboard, then acks.
   initial begin
      logic [W-1:0] got;
      logic [W-1:0] exp_w;
      int           dly;
      bit           ok;
      AER_OUT_ACK = 1'b0;
      forever begin
         @(negedge CLK);
         if (RST_N && AER_OUT_REQ && !AER_OUT_ACK && !rx_hold) begin
            got = AER_OUT_ADDR;
            n_rx++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_event: got 0x%0h, expected no event at %0t", got, $time);
            end else begin
               exp_w = exp_q.pop_front();
               check("aer_word", 32'(got), 32'(exp_w));
            end
            dly = $urandom_range(0, 3);
            repeat (dly) @(negedge CLK);
            if (dly > 0) check("addr_stable", 32'(AER_OUT_ADDR), 32'(got));
            AER_OUT_ACK = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 20; k++) begin
               @(negedge CLK);
               if (!AER_OUT_REQ) begin
                  ok = 1'b1;
                  break;
               end
            end
            check("req_release", 32'(ok), 32'd1);
            AER_OUT_ACK = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      logic [P-1:0] rv;
      RST_N           = 1'b0;
      SPIKE_VALID     = 1'b0;
      SPIKE_VEC       = '0;
      SPIKE_BASE_ADDR = '0;
      CLR_OVERFLOW    = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_ready", 32'(SPIKE_READY), 32'd1);
      check("rst_addr", 32'(AER_OUT_ADDR), 32'd0);
      check("rst_req", 32'(AER_OUT_REQ), 32'd0);
      check("rst_count", 32'(FIFO_COUNT), 32'd0);
      check("rst_ovf", 32'(OVERFLOW), 32'd0);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      // 1: three-spike vector, latency and READY timing
      send_vec(1'b1, 4'b1011, 'h010, 1'b0);
      check("t1_ready_c0", 32'(SPIKE_READY), 32'd0);
      check("t1_req_c0", 32'(AER_OUT_REQ), 32'd0);
      @(negedge CLK);
      check("t1_ready_c1", 32'(SPIKE_READY), 32'd0);
      check("t1_req_c1", 32'(AER_OUT_REQ), 32'd0);
      @(negedge CLK);
      check("t1_ready_c2", 32'(SPIKE_READY), 32'd0);
      check("t1_req_c2", 32'(AER_OUT_REQ), 32'd1);
      @(negedge CLK);
      check("t1_ready_c3", 32'(SPIKE_READY), 32'd1);
      wait_drain();

      // 2: empty vector is ignored
      send_vec(1'b1, 4'b0000, 'h040, 1'b0);
      check("t2_ready", 32'(SPIKE_READY), 32'd1);
      repeat (5) @(negedge CLK);
      check("t2_req", 32'(AER_OUT_REQ), 32'd0);
      check("t2_count", 32'(FIFO_COUNT), 32'd0);

      // 3: fill FIFO with ACK held, stage one more, drop the next
      rx_hold = 1'b1;
      for (int v = 0; v < 5; v++) begin
         wait_ready();
         send_vec(1'b1, 4'b1111, v * 4, 1'b0);
      end
      send_vec(1'b1, 4'b1111, 20, 1'b0);
      check("t3_ovf", 32'(OVERFLOW), 32'd1);
      repeat (6) @(negedge CLK);
      check("t3_count_full", 32'(FIFO_COUNT), 32'd16);
      check("t3_ready_stall", 32'(SPIKE_READY), 32'd0);
      check("t3_req_held", 32'(AER_OUT_REQ), 32'd1);

      // 4: drop beats a simultaneous clear; clear alone wins later
      send_vec(1'b1, 4'b0001, 24, 1'b1);
      check("t4_ovf_set_prio", 32'(OVERFLOW), 32'd1);
      send_vec(1'b0, 4'b0000, 0, 1'b1);
      check("t4_ovf_clr", 32'(OVERFLOW), 32'd0);

      // release: first pop coincides with a push at full
      rx_hold = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (!AER_OUT_REQ) begin
            ok = 1'b1;
            break;
         end
      end
      check("t5_first_pop", 32'(ok), 32'd1);
      check("t5_count_pushpop", 32'(FIFO_COUNT), 32'd16);
      wait_drain();

      // 5: address at top of range
      send_vec(1'b1, 4'b1000, 'h3FC, 1'b0);
      wait_drain();

      // random traffic
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 5)) @(negedge CLK);
         rv = P'($urandom_range(0, 15));
         send_vec(1'b1, rv, $urandom_range(0, 255) * 4, ($urandom_range(0, 7) == 0));
      end
      wait_drain();

      // 6: asynchronous reset mid-handshake
      rx_hold = 1'b1;
      send_vec(1'b1, 4'b1111, 'h100, 1'b0);
      send_vec(1'b1, 4'b0001, 'h200, 1'b0);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (AER_OUT_REQ) begin
            ok = 1'b1;
            break;
         end
      end
      check("t6_req_up", 32'(ok), 32'd1);
      #2;
      RST_N = 1'b0;
      #1;
      check("t6_req_async", 32'(AER_OUT_REQ), 32'd0);
      check("t6_count_async", 32'(FIFO_COUNT), 32'd0);
      check("t6_ovf_async", 32'(OVERFLOW), 32'd0);
      check("t6_ready_async", 32'(SPIKE_READY), 32'd1);
      exp_q.delete();
      model_ovf = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      rx_hold = 1'b0;
      repeat (40) @(negedge CLK);
      check("t6_no_stale_req", 32'(AER_OUT_REQ), 32'd0);
      check("t6_no_stale_cnt", 32'(FIFO_COUNT), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
